// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED controller: N_CH channels in OFF/ON/PWM/BLINK mode, shared prescaled
// timebase, registered readback on the store/load strobe bus.
module mmio_led_ctrl #(
    parameter int unsigned N_CH      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h2000,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned DIV_BITS  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     m_addr,
    input  logic [31:0]     m_data,
    input  logic            wea,
    input  logic            rea,
    output logic [31:0]     rdata,
    output logic            rvalid,
    output logic [N_CH-1:0] led
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_PWM   = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    logic [1:0]          mode_q [N_CH];
    logic [PWM_BITS-1:0] duty_q [N_CH];
    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                phase_q, phase_d;
    logic [N_CH-1:0]     led_q, led_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q;

    logic [31:0]     offset;
    logic [29:0]     word;
    logic            in_window;
    logic            div_hit;
    logic [N_CH-1:0] ch_hit;
    logic            div_wr;
    logic            tick;
    logic [31:0]     rd_val;
    logic            unused_ok;

    // Addresses below BASE_ADDR would wrap in the subtraction, so they are excluded explicitly.
    assign offset    = m_addr - BASE_ADDR;
    assign word      = offset[31:2];
    assign in_window = (m_addr[1:0] == 2'b00) && (m_addr >= BASE_ADDR);
    assign div_hit   = in_window && (word == 30'(N_CH));
    assign div_wr    = wea && div_hit;
    assign unused_ok = ^{m_data, offset[1:0]};

    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            ch_hit[i] = in_window && (word == 30'(i));
        end
    end

    assign tick = (presc_q == div_q);

    // A DIV write restarts the whole timebase so blink phase is deterministic after reprogramming.
    always_comb begin
        presc_d = tick ? '0 : presc_q + DIV_BITS'(1);
        pwm_d   = tick ? pwm_q + PWM_BITS'(1) : pwm_q;
        phase_d = (tick && (&pwm_q)) ? ~phase_q : phase_q;
        if (div_wr) begin
            presc_d = '0;
            pwm_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_PWM:   led_d[i] = (pwm_q < duty_q[i]);
                MODE_BLINK: led_d[i] = phase_q;
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    // Readback uses the pre-write register contents, so a same-cycle store is not visible yet.
    always_comb begin
        rd_val = '0;
        if (div_hit) begin
            rd_val[DIV_BITS-1:0] = div_q;
        end
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_hit[i]) begin
                rd_val[1:0]           = mode_q[i];
                rd_val[8 +: PWM_BITS] = duty_q[i];
            end
        end
        rdata_d = rea ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                mode_q[i] <= '0;
                duty_q[i] <= '0;
            end
            div_q    <= '0;
            presc_q  <= '0;
            pwm_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (wea && ch_hit[i]) begin
                    mode_q[i] <= m_data[1:0];
                    duty_q[i] <= m_data[8 +: PWM_BITS];
                end
            end
            if (div_wr) begin
                div_q <= m_data[DIV_BITS-1:0];
            end
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rea;
        end
    end

    assign led    = led_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
